// File: rtl/vector_read_unit.sv
// vector_read_unit: issues N strided memory reads, one per cycle, and captures
// the returning words into a flat I x L result vector after a fixed read latency.
module vector_read_unit #(
  parameter int unsigned I      = 20,
  parameter int unsigned L      = 32,
  parameter int unsigned A      = 6,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op_type,
  input  logic [A-1:0]           base_address,
  input  logic [A-1:0]           stride,
  input  logic [$clog2(I+1)-1:0] length,
  input  logic [L-1:0]           read_data,
  output logic                   read_en,
  output logic [A-1:0]           read_address,
  output logic [I*L-1:0]         vector_data,
  output logic [L-1:0]           scalar_data,
  output logic                   busy,
  output logic                   finished,
  output logic                   err
);

  localparam int unsigned W = $clog2(I + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   stride_q, stride_d;
  logic [W-1:0]   n_q, n_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           read_en_q, read_en_d;
  logic [A-1:0]   read_address_q, read_address_d;
  logic           busy_q, busy_d;
  logic           finished_q, finished_d;
  logic           err_q, err_d;
  logic           err_pend_q, err_pend_d;
  logic [I*L-1:0] vector_data_q, vector_data_d;
  logic           pipe_vld_q [RD_LAT];
  logic           pipe_vld_d [RD_LAT];
  logic [W-1:0]   pipe_idx_q [RD_LAT];
  logic [W-1:0]   pipe_idx_d [RD_LAT];
  logic           cap_last;

  // Next-state, issue sequencing, capture pipeline and result capture.
  always_comb begin
    state_d        = state_q;
    stride_d       = stride_q;
    n_d            = n_q;
    cnt_d          = cnt_q;
    read_en_d      = read_en_q;
    read_address_d = read_address_q;
    busy_d         = busy_q;
    finished_d     = 1'b0;
    err_d          = 1'b0;
    err_pend_d     = err_pend_q;
    vector_data_d  = vector_data_q;
    cap_last       = 1'b0;

    pipe_vld_d[0] = read_en_q;
    pipe_idx_d[0] = cnt_q;
    for (int unsigned j = 1; j < RD_LAT; j++) begin
      pipe_vld_d[j] = pipe_vld_q[j-1];
      pipe_idx_d[j] = pipe_idx_q[j-1];
    end

    if (pipe_vld_q[RD_LAT-1]) begin
      for (int unsigned k = 0; k < I; k++) begin
        if (pipe_idx_q[RD_LAT-1] == W'(k)) begin
          vector_data_d[k*L +: L] = read_data;
        end
      end
      cap_last = (pipe_idx_q[RD_LAT-1] == n_q - W'(1));
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          stride_d       = stride;
          read_address_d = base_address;
          cnt_d          = '0;
          busy_d         = 1'b1;
          if (op_type && ((length == '0) || (length > W'(I)))) begin
            state_d    = DONE;
            err_pend_d = 1'b1;
          end else begin
            state_d       = ISSUE;
            read_en_d     = 1'b1;
            n_d           = op_type ? length : W'(1);
            vector_data_d = '0;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == n_q - W'(1)) begin
          read_en_d = 1'b0;
          state_d   = DRAIN;
        end else begin
          cnt_d          = cnt_q + W'(1);
          read_address_d = read_address_q + stride_q;
        end
      end
      DRAIN: begin
        if (cap_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // finished/err are registered on the DONE exit edge, so they are seen
        // while the state is already IDLE and a new start can be taken at once.
        state_d    = IDLE;
        busy_d     = 1'b0;
        finished_d = 1'b1;
        err_d      = err_pend_q;
        err_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      stride_q       <= '0;
      n_q            <= '0;
      cnt_q          <= '0;
      read_en_q      <= 1'b0;
      read_address_q <= '0;
      busy_q         <= 1'b0;
      finished_q     <= 1'b0;
      err_q          <= 1'b0;
      err_pend_q     <= 1'b0;
      vector_data_q  <= '0;
      for (int unsigned j = 0; j < RD_LAT; j++) begin
        pipe_vld_q[j] <= 1'b0;
        pipe_idx_q[j] <= '0;
      end
    end else begin
      state_q        <= state_d;
      stride_q       <= stride_d;
      n_q            <= n_d;
      cnt_q          <= cnt_d;
      read_en_q      <= read_en_d;
      read_address_q <= read_address_d;
      busy_q         <= busy_d;
      finished_q     <= finished_d;
      err_q          <= err_d;
      err_pend_q     <= err_pend_d;
      vector_data_q  <= vector_data_d;
      for (int unsigned j = 0; j < RD_LAT; j++) begin
        pipe_vld_q[j] <= pipe_vld_d[j];
        pipe_idx_q[j] <= pipe_idx_d[j];
      end
    end
  end

  assign read_en      = read_en_q;
  assign read_address = read_address_q;
  assign vector_data  = vector_data_q;
  assign scalar_data  = vector_data_q[L-1:0];
  assign busy         = busy_q;
  assign finished     = finished_q;
  assign err          = err_q;

endmodule

// File: tb/tb_vector_read_unit.sv
// Testbench for vector_read_unit: two instances (RD_LAT=1 and RD_LAT=3), each
// attached to a memory whose word equals its address.
module tb_vector_read_unit;

  localparam int unsigned I = 20;
  localparam int unsigned L = 32;
  localparam int unsigned A = 6;
  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start1, start3;
  logic         op_type;
  logic [A-1:0] base_address, stride;
  logic [W-1:0] length;

  logic [L-1:0]   rd1, rd3, sd1, sd3;
  logic           re1, re3, busy1, busy3, fin1, fin3, err1, err3;
  logic [A-1:0]   ra1, ra3;
  logic [I*L-1:0] vd1, vd3;

  always #5 clk = ~clk;

  vector_read_unit #(.I(I), .L(L), .A(A), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .start(start1), .op_type(op_type),
    .base_address(base_address), .stride(stride), .length(length),
    .read_data(rd1), .read_en(re1), .read_address(ra1), .vector_data(vd1),
    .scalar_data(sd1), .busy(busy1), .finished(fin1), .err(err1));

  vector_read_unit #(.I(I), .L(L), .A(A), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .start(start3), .op_type(op_type),
    .base_address(base_address), .stride(stride), .length(length),
    .read_data(rd3), .read_en(re3), .read_address(ra3), .vector_data(vd3),
    .scalar_data(sd3), .busy(busy3), .finished(fin3), .err(err3));

  // Memory models: word = address, returned RD_LAT cycles after the strobe.
  logic [L-1:0] m1 = '0;
  logic [L-1:0] m3 [3];
  initial for (int i = 0; i < 3; i++) m3[i] = '0;
  always @(posedge clk) begin
    if (re1) m1 <= 32'(ra1);
    if (re3) m3[0] <= 32'(ra3);
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign rd1 = m1;
  assign rd3 = m3[2];

  // View of whichever instance the current test targets.
  bit             sel3 = 1'b0;
  logic           re, busy, fin, err;
  logic [A-1:0]   ra;
  logic [I*L-1:0] vd;
  logic [L-1:0]   sd;
  assign re   = sel3 ? re3 : re1;
  assign ra   = sel3 ? ra3 : ra1;
  assign busy = sel3 ? busy3 : busy1;
  assign fin  = sel3 ? fin3 : fin1;
  assign err  = sel3 ? err3 : err1;
  assign vd   = sel3 ? vd3 : vd1;
  assign sd   = sel3 ? sd3 : sd1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_vec(input string nm, input logic [I*L-1:0] act, input logic [I*L-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      for (int k = 0; k < int'(I); k++) begin
        if (act[k*L +: L] !== exp[k*L +: L]) begin
          $display("FAIL %s item %0d: got %0h expected %0h", nm, k, act[k*L +: L], exp[k*L +: L]);
          break;
        end
      end
    end
  endtask

  function automatic logic [I*L-1:0] model_vec(input int base, input int strd, input int n);
    logic [I*L-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*L +: L] = 32'((base + k * strd) % 64);
    return v;
  endfunction

  typedef struct {
    bit         lat3;
    bit         op;
    logic [5:0] base;
    logic [5:0] strd;
    logic [4:0] len;
    int         exp_n;
    bit         exp_err;
    int         exp_lat;
  } vec_t;

  // Run one transfer and check latency, flags, addresses and captured data.
  task automatic apply(input string tag, input vec_t v);
    int             cyc, got_lat;
    logic           got_err, got_busy;
    logic [I*L-1:0] prev, expv;
    int             a[$];
    sel3 = v.lat3;
    @(negedge clk);
    prev         = vd;
    op_type      = v.op;
    base_address = v.base;
    stride       = v.strd;
    length       = v.len;
    if (v.lat3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    cyc = 0; got_lat = 0; got_err = 1'bx; got_busy = 1'bx;
    while (got_lat == 0 && cyc < 80) begin
      @(negedge clk);
      if (cyc == 0) begin
        start1 = 1'b0; start3 = 1'b0;
        chk({tag, " busy_c0"}, busy, 1);
      end
      if (re) a.push_back(int'(ra));
      @(posedge clk); #1; cyc++;
      if (fin) begin got_lat = cyc; got_err = err; got_busy = busy; end
    end
    chk({tag, " latency"}, got_lat, v.exp_lat);
    chk({tag, " err"}, got_err, v.exp_err);
    chk({tag, " busy_at_finish"}, got_busy, 0);
    chk({tag, " read_count"}, a.size(), v.exp_n);
    for (int k = 0; k < a.size() && k < v.exp_n; k++)
      chk($sformatf("%s addr[%0d]", tag, k), a[k], (int'(v.base) + k * int'(v.strd)) % 64);
    expv = v.exp_err ? prev : model_vec(int'(v.base), int'(v.strd), v.exp_n);
    chk_vec({tag, " vector_data"}, vd, expv);
    chk({tag, " scalar_data"}, sd, expv[L-1:0]);
    @(posedge clk); #1;
    chk({tag, " finished_pulse"}, {fin, err}, 2'b00);
  endtask

  vec_t tbl [8];
  int   nre, nfin, lat;
  logic [I*L-1:0] e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         lat3 op base   strd   len    n   err lat
    tbl[0] = '{1'b0, 1, 6'd4,  6'd1,  5'd20, 20, 0, 22};
    tbl[1] = '{1'b1, 1, 6'd60, 6'd3,  5'd4,  4,  0, 8};
    tbl[2] = '{1'b0, 0, 6'd9,  6'd5,  5'd7,  1,  0, 3};
    tbl[3] = '{1'b0, 1, 6'd10, 6'd0,  5'd5,  5,  0, 7};
    tbl[4] = '{1'b0, 1, 6'd12, 6'd1,  5'd0,  0,  1, 1};
    tbl[5] = '{1'b1, 1, 6'd12, 6'd1,  5'd21, 0,  1, 1};
    tbl[6] = '{1'b1, 1, 6'd63, 6'd63, 5'd3,  3,  0, 7};
    tbl[7] = '{1'b1, 0, 6'd9,  6'd1,  5'd7,  1,  0, 5};

    rst = 1'b0; start1 = 1'b0; start3 = 1'b0;
    op_type = 1'b0; base_address = '0; stride = '0; length = '0;
    repeat (3) @(negedge clk);
    chk("reset re1/busy1/fin1/err1", {re1, busy1, fin1, err1}, 4'b0);
    chk("reset re3/busy3/fin3/err3", {re3, busy3, fin3, err3}, 4'b0);
    chk_vec("reset vd1", vd1, '0);
    chk_vec("reset vd3", vd3, '0);
    rst = 1'b1;

    for (int t = 0; t < 8; t++) apply($sformatf("vec%0d", t), tbl[t]);

    // Reset in the middle of a 20-item read, then a normal transfer.
    sel3 = 1'b0;
    @(negedge clk);
    op_type = 1'b1; base_address = 6'd4; stride = 6'd1; length = 5'd20; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start1 = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("midrst item3 before reset", vd1[3*L +: L], 7);
    #1 rst = 1'b0;
    #1;
    chk("midrst re/busy/fin/err async", {re1, busy1, fin1, err1}, 4'b0);
    chk_vec("midrst vd async", vd1, '0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst no stale activity", {re1, busy1, fin1}, 3'b0);
    chk_vec("midrst stale data discarded", vd1, '0);
    apply("post_reset", '{1'b0, 1, 6'd30, 6'd2, 5'd3, 3, 0, 5});

    // Start held high while busy must not restart the transfer.
    sel3 = 1'b0;
    @(negedge clk);
    op_type = 1'b1; base_address = 6'd20; stride = 6'd1; length = 5'd3; start1 = 1'b1;
    @(posedge clk);
    nre = 0; nfin = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) start1 = 1'b0;
      if (re1) nre++;
      if (fin1) nfin++;
    end
    chk("held_start read_count", nre, 3);
    chk("held_start finished_count", nfin, 1);
    chk_vec("held_start vector_data", vd1, model_vec(20, 1, 3));

    // Start during the finished cycle is taken on the very next edge.
    @(negedge clk);
    op_type = 1'b1; base_address = 6'd40; stride = 6'd1; length = 5'd2; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start1 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (fin1) lat = c;
    end
    chk("b2b first latency", lat, 4);
    base_address = 6'd50; stride = 6'd2; length = 5'd3; start1 = 1'b1;
    @(posedge clk); #1;
    chk("b2b accepted re/busy/fin", {re1, busy1, fin1}, 3'b110);
    chk("b2b first address", ra1, 50);
    @(negedge clk); start1 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (fin1) lat = c;
    end
    chk("b2b second latency", lat, 5);
    e = model_vec(50, 2, 3);
    chk_vec("b2b second vector_data", vd1, e);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_read_unit.md
VECTOR_READ_UNIT -- requirements
Module: vector_read_unit

Interface
REQ-001 SHALL have parameter I, default 20: maximum number of vector items.
REQ-002 SHALL have parameter L, default 32: item width in bits.
REQ-003 SHALL have parameter A, default 6: memory address width in bits.
REQ-004 SHALL have parameter RD_LAT, default 1, legal range 1..4: memory read latency in cycles.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: request a new transfer.
REQ-008 SHALL have port op_type, input, 1 bit: 0 = scalar read (1 item), 1 = vector read.
REQ-009 SHALL have port base_address, input, A bits: address of item 0.
REQ-010 SHALL have port stride, input, A bits: address increment between items.
REQ-011 SHALL have port length, input, $clog2(I+1) bits: item count for a vector read.
REQ-012 SHALL have port read_data, input, L bits: memory read data.
REQ-013 SHALL have port read_en, output, 1 bit: memory read strobe.
REQ-014 SHALL have port read_address, output, A bits: memory read address.
REQ-015 SHALL have port vector_data, output, I x L bits: captured items.
REQ-016 SHALL have port scalar_data, output, L bits: always equal to vector_data[0].
REQ-017 SHALL have port busy, output, 1 bit: transfer in progress.
REQ-018 SHALL have port finished, output, 1 bit: one-cycle completion pulse.
REQ-019 SHALL have port err, output, 1 bit: one-cycle pulse flagging an illegal length.

Function
REQ-020 SHALL implement an FSM with states IDLE, ISSUE, DRAIN and DONE.
REQ-021 SHALL sample start only in IDLE; start while busy=1 SHALL be ignored, and op_type, base_address, stride and length SHALL be latched at the accepting edge E0.
REQ-022 SHALL set item count N=1 when op_type=0 (length ignored), else N=length.
REQ-023 SHALL, for a vector read with length=0 or length>I, issue no reads, leave vector_data unchanged, and pulse err and finished together in the cycle after E0.
REQ-024 SHALL clear vector_data to 0 at E0 for a legal transfer.
REQ-025 SHALL, in ISSUE, drive read_en=1 and read_address=base+k*stride (mod 2^A) in cycle k after E0, for k=0..N-1, one item per cycle with no gaps.
REQ-026 SHALL keep read_en=0 in every state except ISSUE.
REQ-027 SHALL capture item k into vector_data[k] at edge E(k+1+RD_LAT), using a RD_LAT-deep valid/index pipeline; items k>=N SHALL remain 0.
REQ-028 SHALL move ISSUE->DRAIN after the last issue and DRAIN->DONE at the last capture edge.
REQ-029 SHALL hold finished=1 for exactly one cycle in DONE, then return to IDLE; total latency from E0 to finished high SHALL be N+RD_LAT+1 cycles.
REQ-030 SHALL hold busy=1 from E0 until the edge at which finished rises.
REQ-031 SHALL allow a start asserted during the DONE cycle to be accepted on the next edge (back-to-back transfers).
REQ-032 SHALL support stride=0, which reads the same address N times.

Reset
REQ-033 SHALL, on rst=0 at any time including mid-transfer, immediately clear state to IDLE and clear read_en, busy, finished, err, vector_data and the capture pipeline; in-flight memory responses SHALL be discarded.
REQ-034 SHALL resume normal operation at the first rising clk edge after rst returns to 1.

Verification
REQ-035 SHALL be tested for a vector read: I=20, RD_LAT=1, base=4, stride=1, length=20, memory word = address -> vector_data[k]=4+k, with finished at cycle 22 after E0.
REQ-036 SHALL be tested for a strided read with wrap: A=6, base=60, stride=3, length=4, RD_LAT=3 -> addresses 60, 63, 2, 5, with finished at cycle 8.
REQ-037 SHALL be tested for a scalar read: op_type=0, length=7, base=9 -> exactly one read_en, scalar_data=mem[9], vector_data[1..19]=0.
REQ-038 SHALL be tested for an illegal length: length=0 and length=21 -> err and finished pulse one cycle after E0, no read_en, vector_data unchanged.
REQ-039 SHALL be tested for reset mid-transfer: rst=0 at cycle 5 of a 20-item read -> all outputs 0 asynchronously, and a new start after release completes normally.
REQ-040 SHALL be tested for start handling: start held during busy is ignored; start in the DONE cycle is accepted with no idle gap.
